// File: rtl/tone_detector_multi.sv
// tone_detector_multi
// Picks the strongest FFT bin that falls inside one of N_TONES tone windows
// and clears a runtime threshold. The per-frame result is debounced over
// CONFIRM_FRAMES frames, and each change is reported once as an event on a
// valid/ready output.
//
// Ports
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   fft_valid_in    input beat valid
//   fft_last_in     last bin of the frame
//   fft_data_in     {real, imag}, two's complement, DATA_WIDTH each
//   fft_ready_out   beat accepted when valid & ready (only in ACCUM)
//   threshold_in    minimum magnitude for a detection, sampled per beat
//   tone_ident_out  reported tone code (0 = no tone, k+1 = tone k)
//   tone_mag_out    magnitude of the reported peak
//   valid_out       event valid, held until ready_in
//   ready_in        downstream accepts the event
//
// state  | meaning
// ACCUM  | accepting bins, tracking the best in-window peak
// DECIDE | one cycle: fold the frame result into the debounce
// REPORT | event presented, waiting for ready_in
module tone_detector_multi #(
    parameter int DATA_WIDTH = 16,
    parameter int FFT_SIZE = 64,
    parameter int N_TONES = 4,
    parameter logic [N_TONES*$clog2(FFT_SIZE)-1:0] TONE_BINS = {6'd30, 6'd20, 6'd10, 6'd5},
    parameter int BIN_TOL = 1,
    parameter int CONFIRM_FRAMES = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          fft_valid_in,
    input  logic                          fft_last_in,
    input  logic [2*DATA_WIDTH-1:0]       fft_data_in,
    output logic                          fft_ready_out,
    input  logic [DATA_WIDTH:0]           threshold_in,
    output logic [$clog2(N_TONES+1)-1:0]  tone_ident_out,
    output logic [DATA_WIDTH:0]           tone_mag_out,
    output logic                          valid_out,
    input  logic                          ready_in
);
    localparam int BIN_W  = $clog2(FFT_SIZE);
    localparam int TONE_W = $clog2(N_TONES+1);
    localparam int CNT_W  = $clog2(CONFIRM_FRAMES+1);

    typedef enum logic [1:0] {ST_ACCUM, ST_DECIDE, ST_REPORT} state_t;

    state_t              state, state_nxt;
    logic [BIN_W-1:0]    bin_cnt;
    logic [TONE_W-1:0]   best_tone, cand, cand_nxt, last_rep, hit_code;
    logic [DATA_WIDTH:0] best_mag;
    logic [CNT_W-1:0]    conf_cnt, conf_nxt;
    logic                hit, accept, upd, report_go;

    // Sign-extend by one bit so that negating the most negative value
    // cannot overflow.
    logic signed [DATA_WIDTH:0] re_ext, im_ext;
    logic [DATA_WIDTH:0]        abs_re, abs_im, mag;

    assign re_ext = {fft_data_in[2*DATA_WIDTH-1], fft_data_in[2*DATA_WIDTH-1:DATA_WIDTH]};
    assign im_ext = {fft_data_in[DATA_WIDTH-1], fft_data_in[DATA_WIDTH-1:0]};
    assign abs_re = re_ext[DATA_WIDTH] ? -re_ext : re_ext;
    assign abs_im = im_ext[DATA_WIDTH] ? -im_ext : im_ext;
    assign mag    = abs_re + abs_im;

    // Scanning from the highest index down lets the lowest matching tone
    // win when windows overlap.
    always_comb begin
        hit      = 1'b0;
        hit_code = '0;
        for (int k = N_TONES - 1; k >= 0; k--) begin
            if ((int'(bin_cnt) - int'(TONE_BINS[k*BIN_W +: BIN_W]) <= BIN_TOL) &&
                (int'(TONE_BINS[k*BIN_W +: BIN_W]) - int'(bin_cnt) <= BIN_TOL)) begin
                hit      = 1'b1;
                hit_code = TONE_W'(k + 1);
            end
        end
    end

    assign accept = fft_valid_in & fft_ready_out;
    assign upd    = accept && hit && (mag >= threshold_in) && (mag > best_mag);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_ACCUM;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        fft_ready_out = 1'b0;
        cand_nxt      = cand;
        conf_nxt      = conf_cnt;
        if (best_tone == cand) begin
            if (conf_cnt != CNT_W'(CONFIRM_FRAMES)) conf_nxt = conf_cnt + 1'b1;
        end else begin
            cand_nxt = best_tone;
            conf_nxt = CNT_W'(1);
        end
        report_go = (conf_nxt == CNT_W'(CONFIRM_FRAMES)) && (cand_nxt != last_rep);
        case (state)
            ST_ACCUM: begin
                fft_ready_out = 1'b1;
                if (fft_valid_in && fft_last_in) state_nxt = ST_DECIDE;
            end
            ST_DECIDE: state_nxt = report_go ? ST_REPORT : ST_ACCUM;
            ST_REPORT: if (ready_in) state_nxt = ST_ACCUM;
            default:   state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bin_cnt        <= '0;
            best_tone      <= '0;
            best_mag       <= '0;
            cand           <= '0;
            conf_cnt       <= '0;
            last_rep       <= '0;
            tone_ident_out <= '0;
            tone_mag_out   <= '0;
            valid_out      <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        if (upd) begin
                            best_tone <= hit_code;
                            best_mag  <= mag;
                        end
                        // FFT_SIZE is a power of two, so the increment wraps
                        // to bin 0 on its own.
                        bin_cnt <= fft_last_in ? '0 : bin_cnt + 1'b1;
                    end
                end
                ST_DECIDE: begin
                    best_tone <= '0;
                    best_mag  <= '0;
                    cand      <= cand_nxt;
                    conf_cnt  <= conf_nxt;
                    if (report_go) begin
                        tone_ident_out <= cand_nxt;
                        tone_mag_out   <= best_mag;
                        valid_out      <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        last_rep  <= cand;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_detector_multi.sv
module tb_tone_detector_multi;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        fft_valid_in;
    logic        fft_last_in;
    logic [31:0] fft_data_in;
    logic        fft_ready_out;
    logic [16:0] threshold_in;
    logic [2:0]  tone_ident_out;
    logic [16:0] tone_mag_out;
    logic        valid_out;
    logic        ready_in;

    always #5 clk_in = ~clk_in;

    tone_detector_multi dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .fft_valid_in   (fft_valid_in),
        .fft_last_in    (fft_last_in),
        .fft_data_in    (fft_data_in),
        .fft_ready_out  (fft_ready_out),
        .threshold_in   (threshold_in),
        .tone_ident_out (tone_ident_out),
        .tone_mag_out   (tone_mag_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int fr_re[80];
    int fr_im[80];
    int fr_len;
    int thr;

    // Debounce reference: candidate, agreement count, last reported code.
    int m_cand, m_cnt, m_last;
    int tone_c[4] = '{5, 10, 20, 30};

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic clear_frame(input int len, input int t);
        for (int i = 0; i < 80; i++) begin
            fr_re[i] = 0;
            fr_im[i] = 0;
        end
        fr_len = len;
        thr    = t;
    endtask

    task automatic model_reset();
        m_cand = 0;
        m_cnt  = 0;
        m_last = 0;
    endtask

    // Strongest in-window bin above threshold; strict improvement only.
    task automatic model_frame(output int code, output int mag);
        code = 0;
        mag  = 0;
        for (int b = 0; b < fr_len; b++) begin
            int bin, m, tone;
            bin  = b % 64;
            m    = iabs(fr_re[b]) + iabs(fr_im[b]);
            tone = 0;
            for (int k = 0; k < 4; k++)
                if (tone == 0 && iabs(bin - tone_c[k]) <= 1) tone = k + 1;
            if (tone != 0 && m >= thr && m > mag) begin
                code = tone;
                mag  = m;
            end
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (fft_ready_out !== 1'b1 && n < 30) begin
            @(posedge clk_in); #1;
            n++;
        end
        n_checks++;
        if (fft_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s wait_ready: fft_ready_out=%b want 1 within 30 cycles", tag, fft_ready_out);
        end
    endtask

    task automatic send_frame(input string tag, input int hold, input bit gaps, input bit ack);
        int r_code, r_mag, exp_code, exp_mag;
        bit exp_ev;
        model_frame(r_code, r_mag);
        if (r_code == m_cand) begin
            if (m_cnt < 2) m_cnt++;
        end else begin
            m_cand = r_code;
            m_cnt  = 1;
        end
        exp_ev   = (m_cnt == 2) && (m_cand != m_last);
        exp_code = m_cand;
        exp_mag  = r_mag;

        threshold_in = thr[16:0];
        for (int b = 0; b < fr_len; b++) begin
            int rv, iv;
            if (gaps && $urandom_range(0, 3) == 0) begin
                fft_valid_in = 1'b0;
                @(posedge clk_in); #1;
            end
            wait_ready(tag);
            rv = fr_re[b];
            iv = fr_im[b];
            fft_valid_in = 1'b1;
            fft_last_in  = (b == fr_len - 1);
            fft_data_in  = {rv[15:0], iv[15:0]};
            @(posedge clk_in); #1;
        end
        fft_valid_in = 1'b0;
        fft_last_in  = 1'b0;

        n_checks++;
        if (fft_ready_out !== 1'b0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s decide_cycle: ready=%b valid=%b want ready=0 valid=0", tag, fft_ready_out, valid_out);
        end
        @(posedge clk_in); #1;
        n_checks++;
        if (valid_out !== exp_ev) begin
            n_fail++;
            $display("FAIL %s event_valid: got %b want %b", tag, valid_out, exp_ev);
        end
        if (exp_ev) begin
            n_checks++;
            if (tone_ident_out !== exp_code[2:0] || tone_mag_out !== exp_mag[16:0] || fft_ready_out !== 1'b0) begin
                n_fail++;
                $display("FAIL %s event_data: code=%0d mag=%0d ready=%b want code=%0d mag=%0d ready=0",
                         tag, tone_ident_out, tone_mag_out, fft_ready_out, exp_code, exp_mag);
            end
            for (int i = 0; i < hold; i++) begin
                ready_in     = 1'b0;
                fft_valid_in = 1'b1;
                fft_last_in  = 1'b1;
                fft_data_in  = $urandom;
                @(posedge clk_in); #1;
                n_checks++;
                if (valid_out !== 1'b1 || fft_ready_out !== 1'b0 ||
                    tone_ident_out !== exp_code[2:0] || tone_mag_out !== exp_mag[16:0]) begin
                    n_fail++;
                    $display("FAIL %s hold_%0d: valid=%b ready=%b code=%0d mag=%0d want 1 0 %0d %0d",
                             tag, i, valid_out, fft_ready_out, tone_ident_out, tone_mag_out, exp_code, exp_mag);
                end
            end
            fft_valid_in = 1'b0;
            fft_last_in  = 1'b0;
            if (ack) begin
                ready_in = 1'b1;
                @(posedge clk_in); #1;
                ready_in = 1'b0;
                m_last   = m_cand;
                n_checks++;
                if (valid_out !== 1'b0 || fft_ready_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s handshake: valid=%b ready=%b want valid=0 ready=1", tag, valid_out, fft_ready_out);
                end
            end
        end else begin
            n_checks++;
            if (fft_ready_out !== 1'b1) begin
                n_fail++;
                $display("FAIL %s back_to_accum: ready=%b want 1", tag, fft_ready_out);
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        n_checks++;
        if (tone_ident_out !== 3'd0 || tone_mag_out !== 17'd0 || valid_out !== 1'b0 || fft_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s reset_outputs: code=%0d mag=%0d valid=%b ready=%b want 0 0 0 1",
                     tag, tone_ident_out, tone_mag_out, valid_out, fft_ready_out);
        end
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n_in = 1'b0;
        #1 check_zero_outputs(tag);
        fft_valid_in = 1'b0;
        fft_last_in  = 1'b0;
        ready_in     = 1'b0;
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n_in     = 1'b0;
        fft_valid_in = 1'b0;
        fft_last_in  = 1'b0;
        fft_data_in  = '0;
        threshold_in = '0;
        ready_in     = 1'b0;
        #12;
        check_zero_outputs("reset");
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        clear_frame(64, 100);
        fr_re[10] = 300;
        fr_im[10] = -200;
        send_frame("basic_f1", 0, 0, 1);
        send_frame("basic_f2", 0, 0, 1);
    endtask

    task automatic test_window_peak();
        clear_frame(64, 100);
        fr_re[4] = 100;
        fr_re[6] = 150;
        send_frame("window_f1", 0, 0, 1);
        send_frame("window_f2", 0, 0, 1);
        send_frame("window_f3", 0, 0, 1);
    endtask

    task automatic test_release();
        clear_frame(64, 100);
        fr_re[10] = 300;
        fr_im[10] = -200;
        send_frame("release_tone_f1", 0, 0, 1);
        send_frame("release_tone_f2", 0, 0, 1);
        clear_frame(64, 100);
        fr_re[20] = 50;
        send_frame("release_f1", 0, 0, 1);
        send_frame("release_f2", 0, 0, 1);
    endtask

    task automatic test_tie_overflow();
        clear_frame(64, 100);
        fr_re[0]  = -32768;
        fr_im[0]  = -32768;
        fr_re[5]  = 400;
        fr_im[20] = -400;
        send_frame("tie_f1", 0, 0, 1);
        send_frame("tie_f2", 0, 0, 1);
        clear_frame(64, 100);
        fr_re[31] = -32768;
        fr_im[31] = -32768;
        send_frame("maxmag_f1", 0, 0, 1);
        send_frame("maxmag_f2", 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        clear_frame(64, 100);
        fr_re[30] = 700;
        fr_im[30] = 700;
        send_frame("bp_f1", 0, 0, 1);
        send_frame("bp_f2", 10, 0, 1);
        clear_frame(64, 100);
        fr_im[11] = 250;
        send_frame("bp_next_f1", 0, 0, 1);
    endtask

    task automatic test_short_wrap();
        clear_frame(12, 100);
        fr_im[11] = 250;
        send_frame("short_f2", 0, 0, 1);
        clear_frame(70, 100);
        fr_re[68] = 200;
        send_frame("wrap_f1", 0, 0, 1);
        send_frame("wrap_f2", 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        threshold_in = 17'd100;
        for (int b = 0; b < 5; b++) begin
            fft_valid_in = 1'b1;
            fft_last_in  = 1'b0;
            fft_data_in  = {16'd500, 16'd0};
            @(posedge clk_in); #1;
        end
        async_reset("reset_mid_frame");
        clear_frame(64, 100);
        fr_re[20] = 600;
        send_frame("rst_tone3_f1", 0, 0, 1);
        send_frame("rst_tone3_f2", 0, 0, 1);
        clear_frame(64, 100);
        fr_im[30] = 900;
        send_frame("rst_rep_f1", 0, 0, 1);
        send_frame("rst_rep_f2", 0, 0, 0);
        async_reset("reset_mid_report");
        clear_frame(64, 100);
        fr_re[20] = 600;
        send_frame("after_rst_f1", 0, 0, 1);
        send_frame("after_rst_f2", 0, 0, 1);
        send_frame("after_rst_f3", 0, 0, 1);
    endtask

    task automatic test_random();
        int pick = 0;
        for (int f = 0; f < 40; f++) begin
            if (f == 0 || $urandom_range(0, 2) == 0) pick = $urandom_range(0, 4);
            clear_frame(64, $urandom_range(80, 300));
            for (int b = 0; b < 64; b++) begin
                fr_re[b] = int'($urandom_range(0, 120)) - 60;
                fr_im[b] = int'($urandom_range(0, 120)) - 60;
            end
            if (pick > 0) begin
                int bin;
                bin = tone_c[pick-1] + int'($urandom_range(0, 2)) - 1;
                fr_re[bin] = int'($urandom_range(0, 65535)) - 32768;
                fr_im[bin] = int'($urandom_range(0, 4000)) - 2000;
            end
            if ($urandom_range(0, 3) == 0) begin
                int bin2;
                bin2 = tone_c[$urandom_range(0, 3)] + int'($urandom_range(0, 2)) - 1;
                fr_re[bin2] = int'($urandom_range(0, 8000)) - 4000;
            end
            send_frame("random", $urandom_range(0, 3), 1, 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window_peak();
        test_release();
        test_tie_overflow();
        test_back_to_back();
        test_short_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
